// File: rtl/decoder_scan_sequencer.sv
// decoder_scan_sequencer
//
// Generates the 4-bit select code {d,c,b,a} and the top-level enable en416
// for a downstream 4-to-16 decoder tree. The code steps up or down at a
// programmable rate (DIV clocks per advance) in RUN. It can be frozen and
// single-stepped in HOLD, and it is cleared in IDLE. A one-pass mode
// returns to IDLE after the first wrap. Every output is a flop, so the
// decoder always sees glitch-free selects.
//
// Ports
//   clk     in   rising-edge clock
//   rst     in   asynchronous active-high reset
//   start   in   enter RUN from IDLE, or resume RUN from HOLD
//   pause   in   RUN -> HOLD
//   halt    in   any state -> IDLE, code cleared
//   step    in   in HOLD, advance the code once per cycle while high
//   dir     in   1 = count up, 0 = count down (sampled on every advance)
//   single  in   sampled on IDLE -> RUN; 1 = one pass, then IDLE
//   d,c,b,a out  select code, d is the MSB
//   en416   out  decoder enable (RUN / HOLD)
//   busy    out  high while running
//   wrap    out  one-cycle pulse on a 15->0 or 0->15 advance
module decoder_scan_sequencer #(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic pause,
    input  logic halt,
    input  logic step,
    input  logic dir,
    input  logic single,
    output logic d,
    output logic c,
    output logic b,
    output logic a,
    output logic en416,
    output logic busy,
    output logic wrap
);

    localparam logic [15:0] PRESC_MAX = 16'(DIV - 32'd1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  code_q, code_d;
    logic [15:0] presc_q, presc_d;
    logic        one_pass_q, one_pass_d;
    logic        wrap_q, wrap_d;
    logic        en416_q, en416_d;
    logic        busy_q, busy_d;
    logic        end_pass_s;

    // Modulo-16 neighbour of the current code in the requested direction.
    function automatic logic [3:0] code_next(input logic [3:0] code, input logic up);
        if (up) begin
            return code + 4'd1;
        end else begin
            return code - 4'd1;
        end
    endfunction

    // True when advancing from this code in this direction crosses the 15/0 seam.
    function automatic logic code_wraps(input logic [3:0] code, input logic up);
        if (up) begin
            return (code == 4'hF);
        end else begin
            return (code == 4'h0);
        end
    endfunction

    // Next-state, code, prescaler and pulse computation with halt > pause > start > step.
    always_comb begin
        state_d    = state_q;
        code_d     = code_q;
        presc_d    = presc_q;
        one_pass_d = one_pass_q;
        wrap_d     = 1'b0;
        end_pass_s = 1'b0;

        case (state_q)
            ST_IDLE: begin
                code_d  = 4'd0;
                presc_d = 16'd0;
                if (halt) begin
                    state_d = ST_IDLE;
                end else if (start) begin
                    state_d    = ST_RUN;
                    one_pass_d = single;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_RUN: begin
                if (halt) begin
                    state_d = ST_IDLE;
                    code_d  = 4'd0;
                    presc_d = 16'd0;
                end else if (pause) begin
                    state_d = ST_HOLD;
                    presc_d = 16'd0;
                end else if (presc_q >= PRESC_MAX) begin
                    code_d  = code_next(code_q, dir);
                    presc_d = 16'd0;
                    if (code_wraps(code_q, dir)) begin
                        wrap_d = 1'b1;
                        // A one-pass run ends on its wrapping advance. The wrapped
                        // code and wrap pulse are still shown for that cycle,
                        // and the enable drops one cycle later.
                        if (one_pass_q) begin
                            state_d    = ST_IDLE;
                            end_pass_s = 1'b1;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    presc_d = presc_q + 16'd1;
                end
            end

            ST_HOLD: begin
                // pause is deliberately not decoded here: HOLD is already paused.
                if (halt) begin
                    state_d = ST_IDLE;
                    code_d  = 4'd0;
                    presc_d = 16'd0;
                end else if (start) begin
                    state_d = ST_RUN;
                    presc_d = 16'd0;
                end else if (step) begin
                    code_d = code_next(code_q, dir);
                    wrap_d = code_wraps(code_q, dir);
                end else begin
                    state_d = ST_HOLD;
                end
            end

            default: begin
                state_d    = ST_IDLE;
                code_d     = 4'd0;
                presc_d    = 16'd0;
                one_pass_d = 1'b0;
            end
        endcase

        // Outputs are derived from the next state so they line up with the state register.
        en416_d = (state_d != ST_IDLE) || end_pass_s;
        busy_d  = (state_d == ST_RUN)  || end_pass_s;
    end

    // State, code, prescaler and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            code_q     <= 4'd0;
            presc_q    <= 16'd0;
            one_pass_q <= 1'b0;
            wrap_q     <= 1'b0;
            en416_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            code_q     <= code_d;
            presc_q    <= presc_d;
            one_pass_q <= one_pass_d;
            wrap_q     <= wrap_d;
            en416_q    <= en416_d;
            busy_q     <= busy_d;
        end
    end

    assign d     = code_q[3];
    assign c     = code_q[2];
    assign b     = code_q[1];
    assign a     = code_q[0];
    assign en416 = en416_q;
    assign busy  = busy_q;
    assign wrap  = wrap_q;

endmodule
